// File: rtl/ddr5_pkg.sv
// Shared widths, FSM state encoding and request layout for the DDR5 request path.
package ddr5_pkg;

  localparam int unsigned ADDR_W         = 20;
  localparam int unsigned DATA_W         = 64;
  localparam int unsigned BANK_W         = 4;
  localparam int unsigned TAG_W          = 4;
  localparam int unsigned TIMEOUT_CYCLES = 1000;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StGap
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  tag;
  } req_t;

endpackage

// File: rtl/ddr5_req_fifo.sv
// In-order request FIFO with extra-MSB pointers and a registered not-full flag.
module ddr5_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             ready,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wptr_q, rptr_q, wptr_d, rptr_d;
  logic             ready_q, full_q, full_d;
  logic             do_push, do_pop;

  assign full_q  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign count   = wptr_q - rptr_q;
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty;
  assign wptr_d  = wptr_q + {{PTR_W{1'b0}}, do_push};
  assign rptr_d  = rptr_q + {{PTR_W{1'b0}}, do_pop};
  assign full_d  = (wptr_d[PTR_W] != rptr_d[PTR_W]) &&
                   (wptr_d[PTR_W-1:0] == rptr_d[PTR_W-1:0]);
  assign rdata   = mem_q[rptr_q[PTR_W-1:0]];
  assign ready   = ready_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[PTR_W-1:0]] <= wdata;
    end
  end

  // ready follows the post-edge occupancy, so a pop while full only frees a slot next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ready_q <= !full_d;
    end
  end

endmodule

// File: rtl/ddr5_req_queue.sv
// Request buffer and one-at-a-time issue sequencer in front of the DDR5 controller CPU port.
module ddr5_req_queue #(
  parameter int unsigned ADDR_W         = ddr5_pkg::ADDR_W,
  parameter int unsigned DATA_W         = ddr5_pkg::DATA_W,
  parameter int unsigned TAG_W          = ddr5_pkg::TAG_W,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = ddr5_pkg::TIMEOUT_CYCLES,
  localparam int unsigned CNT_W         = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] CPU_ADDR,
  output logic [DATA_W-1:0] CPU_WRT_DATA,
  output logic              CPU_WE,
  output logic              CPU_VALID,
  input  logic              CPU_READY,
  input  logic [DATA_W-1:0] CPU_RD_DATA,
  output logic [CNT_W-1:0]  q_count,
  output logic [7:0]        err_count
);
  import ddr5_pkg::*;

  localparam int unsigned REQ_W = 1 + ADDR_W + DATA_W + TAG_W;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [TAG_W-1:0]  tag_q, rsp_tag_q;
  logic              we_q, valid_q, rsp_valid_q, rsp_we_q, rsp_err_q;
  logic [7:0]        err_cnt_q;

  logic [REQ_W-1:0]  head;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [TAG_W-1:0]  head_tag;
  logic              fifo_empty, pop, push;

  assign push = req_valid && req_ready;
  // Only issue when the response slot is free now or is being drained on this edge
  assign pop  = (state_q == StIdle) && !fifo_empty && (!rsp_valid_q || rsp_ready);
  assign {head_we, head_addr, head_wdata, head_tag} = head;

  ddr5_req_fifo #(
    .WIDTH(REQ_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata({req_we, req_addr, req_wdata, req_tag}),
    .pop  (pop),
    .rdata(head),
    .empty(fifo_empty),
    .ready(req_ready),
    .count(q_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_tag_q   <= '0;
      rdata_q     <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            addr_q  <= head_addr;
            wdata_q <= head_wdata;
            we_q    <= head_we;
            tag_q   <= head_tag;
            valid_q <= 1'b1;
            timer_q <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          timer_q <= timer_q + TMR_W'(1);
          // A completion on the final timer cycle still counts as success
          if (CPU_READY || (timer_q == TmrLast)) begin
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= we_q;
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= !CPU_READY;
            rdata_q     <= (CPU_READY && !we_q) ? CPU_RD_DATA : '0;
            if (!CPU_READY && (err_cnt_q != 8'hFF)) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
            valid_q <= 1'b0;
            state_q <= StGap;
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign CPU_ADDR     = addr_q;
  assign CPU_WRT_DATA = wdata_q;
  assign CPU_WE       = we_q;
  assign CPU_VALID    = valid_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_we       = rsp_we_q;
  assign rsp_tag      = rsp_tag_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = rsp_err_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_ddr5_req_queue.sv
// Scoreboard bench for ddr5_req_queue with a behavioural controller model on the CPU port.
module tb_ddr5_req_queue;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic              rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [TAG_W-1:0]  rsp_tag;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [DATA_W-1:0] CPU_WRT_DATA, CPU_RD_DATA;
  logic              CPU_WE, CPU_VALID, CPU_READY;
  logic [CNT_W-1:0]  q_count;
  logic [7:0]        err_count;

  typedef struct {
    logic              we;
    logic [TAG_W-1:0]  tag;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] shadow   [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ctrl_mem [logic [ADDR_W-1:0]];
  int                n_checks = 0;
  int                n_pass   = 0;
  bit                ctrl_en  = 1'b0;
  int                ctrl_delay = 0;
  int                ctrl_cnt   = 0;
  logic [7:0]        exp_errs   = '0;

  always #5 clk = ~clk;

  ddr5_req_queue #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .TAG_W         (TAG_W),
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_we      (rsp_we),
    .rsp_tag     (rsp_tag),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .CPU_ADDR    (CPU_ADDR),
    .CPU_WRT_DATA(CPU_WRT_DATA),
    .CPU_WE      (CPU_WE),
    .CPU_VALID   (CPU_VALID),
    .CPU_READY   (CPU_READY),
    .CPU_RD_DATA (CPU_RD_DATA),
    .q_count     (q_count),
    .err_count   (err_count)
  );

  // Controller model: one-cycle CPU_READY pulse ctrl_delay cycles after CPU_VALID is seen
  initial begin
    CPU_READY   = 1'b0;
    CPU_RD_DATA = '0;
    forever begin
      @(negedge clk);
      if (CPU_READY) begin
        CPU_READY   = 1'b0;
        CPU_RD_DATA = '0;
        ctrl_cnt    = 0;
      end else if (!rst || !CPU_VALID) begin
        ctrl_cnt = 0;
      end else if (ctrl_en) begin
        if (ctrl_cnt >= ctrl_delay) begin
          CPU_READY = 1'b1;
          if (CPU_WE) ctrl_mem[CPU_ADDR] = CPU_WRT_DATA;
          else CPU_RD_DATA = ctrl_mem.exists(CPU_ADDR) ? ctrl_mem[CPU_ADDR] : '0;
        end else begin
          ctrl_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t next_exp();
    exp_t e = '{we: 1'b0, tag: '0, err: 1'b0, rdata: '0};
    if (exp_q.size() != 0) e = exp_q.pop_front();
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data, input logic [TAG_W-1:0] tag,
                      input bit will_err);
    exp_t e;
    int   n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    req_tag   = tag;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL send_accept tag %0d: req_ready=%b, want 1", tag, req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    e.we    = we;
    e.tag   = tag;
    e.err   = will_err;
    e.rdata = (we || will_err) ? '0 : (shadow.exists(addr) ? shadow[addr] : '0);
    if (we && !will_err) shadow[addr] = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_rsp(input int limit);
    int n = 0;
    while (!rsp_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_tag = '0; rsp_ready = 1'b0;
    #3;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b, want 0", req_ready); else n_pass++;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_we} !== 3'b000)
      $display("FAIL rst_rsp: got valid/err/we %b%b%b, want 000", rsp_valid, rsp_err, rsp_we);
    else n_pass++;
    n_checks++;
    if ({CPU_VALID, CPU_WE, CPU_ADDR} !== '0)
      $display("FAIL rst_cpu: got valid=%b we=%b addr=%h, want 0", CPU_VALID, CPU_WE, CPU_ADDR);
    else n_pass++;
    n_checks++;
    if ({q_count, err_count} !== '0)
      $display("FAIL rst_counts: got q_count=%0d err_count=%0d, want 0", q_count, err_count);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b, want 1", req_ready); else n_pass++;
  endtask

  task automatic test_write();
    exp_t e;
    ctrl_en = 1'b1; ctrl_delay = 2;
    send(1'b1, 20'h01000, 64'hDEAD_BEEF_CAFE_BABE, 4'd1, 1'b0);
    n_checks++;
    if (CPU_VALID !== 1'b0) $display("FAIL wr_latency_early: CPU_VALID=%b, want 0", CPU_VALID); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({CPU_VALID, CPU_WE, CPU_ADDR, CPU_WRT_DATA} !== {1'b1, 1'b1, 20'h01000, 64'hDEAD_BEEF_CAFE_BABE})
      $display("FAIL wr_issue: got valid=%b we=%b addr=%h data=%h, want 1 1 01000 deadbeefcafebabe",
               CPU_VALID, CPU_WE, CPU_ADDR, CPU_WRT_DATA);
    else n_pass++;
    wait_rsp(50);
    e = next_exp();
    n_checks++;
    if ({rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata} !== {1'b1, e.we, e.tag, e.err, e.rdata})
      $display("FAIL wr_rsp: got v=%b we=%b tag=%0d err=%b rd=%h, want v=1 we=%b tag=%0d err=%b rd=%h",
               rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata, e.we, e.tag, e.err, e.rdata);
    else n_pass++;
    n_checks++;
    if (CPU_VALID !== 1'b0) $display("FAIL wr_gap: CPU_VALID=%b at response, want 0", CPU_VALID); else n_pass++;
    ack();
  endtask

  task automatic test_read();
    exp_t e;
    ctrl_en = 1'b1; ctrl_delay = 0;
    send(1'b0, 20'h01000, '0, 4'd2, 1'b0);
    wait_rsp(50);
    e = next_exp();
    n_checks++;
    if ({rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata} !== {1'b1, e.we, e.tag, e.err, e.rdata})
      $display("FAIL rd_rsp: got v=%b we=%b tag=%0d err=%b rd=%h, want v=1 we=%b tag=%0d err=%b rd=%h",
               rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata, e.we, e.tag, e.err, e.rdata);
    else n_pass++;
    ack();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   bad = 0;
    ctrl_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send((i % 2) == 0, ADDR_W'(32'h02000 + 32'(i / 2) * 32'h10),
           {32'hA5A5_0000 + 32'(i), 32'(i) * 32'h0101_0101}, TAG_W'(i), 1'b0);
      if (i == 3) begin
        n_checks++;
        if (q_count !== CNT_W'(3)) $display("FAIL b2b_count3: got %0d, want 3", q_count); else n_pass++;
      end
    end
    n_checks++;
    if ({q_count, req_ready} !== {CNT_W'(4), 1'b0})
      $display("FAIL b2b_full: got q_count=%0d req_ready=%b, want 4 0", q_count, req_ready);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || q_count !== CNT_W'(4) || CPU_VALID !== 1'b1 || CPU_ADDR !== 20'h02000)
        bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL b2b_stall_hold: %0d bad cycles, want 0", bad); else n_pass++;
    ctrl_en = 1'b1; ctrl_delay = 1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(100);
      e = next_exp();
      n_checks++;
      if ({rsp_valid, CPU_VALID, rsp_we, rsp_tag, rsp_err, rsp_rdata} !==
          {1'b1, 1'b0, e.we, e.tag, e.err, e.rdata})
        $display("FAIL b2b_rsp%0d: got v=%b cpuv=%b we=%b tag=%0d err=%b rd=%h, want 1 0 %b %0d %b %h",
                 i, rsp_valid, CPU_VALID, rsp_we, rsp_tag, rsp_err, rsp_rdata,
                 e.we, e.tag, e.err, e.rdata);
      else n_pass++;
      ack();
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   hi = 0;
    int   n  = 0;
    int   bad = 0;
    ctrl_en = 1'b0;
    send(1'b0, 20'h03000, '0, 4'd5, 1'b1);
    send(1'b1, 20'h03100, 64'h0123_4567_89AB_CDEF, 4'd6, 1'b0);
    while (!rsp_valid && n < 1200) begin
      if (CPU_VALID) hi++;
      @(negedge clk);
      n++;
    end
    exp_errs++;
    ctrl_en = 1'b1; ctrl_delay = 0;
    n_checks++;
    if (hi != TIMEOUT) $display("FAIL to_wait_cycles: got %0d, want %0d", hi, TIMEOUT); else n_pass++;
    e = next_exp();
    n_checks++;
    if ({rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata} !== {1'b1, e.we, e.tag, e.err, e.rdata})
      $display("FAIL to_rsp: got v=%b we=%b tag=%0d err=%b rd=%h, want v=1 we=%b tag=%0d err=%b rd=%h",
               rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata, e.we, e.tag, e.err, e.rdata);
    else n_pass++;
    n_checks++;
    if ({err_count, CPU_VALID} !== {exp_errs, 1'b0})
      $display("FAIL to_err_count: got %0d cpuv=%b, want %0d 0", err_count, CPU_VALID, exp_errs);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (CPU_VALID !== 1'b0 || q_count !== CNT_W'(1)) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL to_blocked: %0d bad cycles, want 0", bad); else n_pass++;
    ack();
    wait_rsp(50);
    e = next_exp();
    n_checks++;
    if ({rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata, err_count} !==
        {1'b1, e.we, e.tag, e.err, e.rdata, exp_errs})
      $display("FAIL to_next: got v=%b we=%b tag=%0d err=%b rd=%h ec=%0d, want 1 %b %0d %b %h %0d",
               rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata, err_count,
               e.we, e.tag, e.err, e.rdata, exp_errs);
    else n_pass++;
    ack();
  endtask

  task automatic test_hold();
    exp_t e;
    logic [DATA_W+TAG_W+1:0] snap;
    int bad = 0;
    ctrl_en = 1'b1; ctrl_delay = 0;
    send(1'b0, 20'h01000, '0, 4'd7, 1'b0);
    send(1'b0, 20'h02000, '0, 4'd8, 1'b0);
    wait_rsp(50);
    e = next_exp();
    n_checks++;
    if ({rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata} !== {1'b1, e.we, e.tag, e.err, e.rdata})
      $display("FAIL hold_rsp1: got v=%b we=%b tag=%0d err=%b rd=%h, want v=1 we=%b tag=%0d err=%b rd=%h",
               rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata, e.we, e.tag, e.err, e.rdata);
    else n_pass++;
    snap = {rsp_we, rsp_err, rsp_tag, rsp_rdata};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || {rsp_we, rsp_err, rsp_tag, rsp_rdata} !== snap ||
          CPU_VALID !== 1'b0 || q_count !== CNT_W'(1))
        bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL hold_stable: %0d bad cycles, want 0", bad); else n_pass++;
    ack();
    wait_rsp(50);
    e = next_exp();
    n_checks++;
    if ({rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata} !== {1'b1, e.we, e.tag, e.err, e.rdata})
      $display("FAIL hold_rsp2: got v=%b we=%b tag=%0d err=%b rd=%h, want v=1 we=%b tag=%0d err=%b rd=%h",
               rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata, e.we, e.tag, e.err, e.rdata);
    else n_pass++;
    ack();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    ctrl_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, ADDR_W'(32'h04000 + 32'(i) * 32'h10), '0, TAG_W'(11 + i), 1'b0);
    end
    n_checks++;
    if ({CPU_VALID, q_count} !== {1'b1, CNT_W'(3)})
      $display("FAIL rmid_pre: got cpuv=%b q_count=%0d, want 1 3", CPU_VALID, q_count);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({CPU_VALID, rsp_valid, q_count, req_ready, err_count} !== '0)
      $display("FAIL rmid_async: got cpuv=%b rspv=%b q_count=%0d ready=%b ec=%0d, want all 0",
               CPU_VALID, rsp_valid, q_count, req_ready, err_count);
    else n_pass++;
    exp_q.delete();
    exp_errs = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ctrl_en = 1'b1; ctrl_delay = 1;
    send(1'b1, 20'h11000, 64'hFEED_FACE_0BAD_F00D, 4'd9, 1'b0);
    send(1'b0, 20'h11000, '0, 4'd10, 1'b0);
    for (int i = 0; i < 2; i++) begin
      wait_rsp(50);
      e = next_exp();
      n_checks++;
      if ({rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata} !== {1'b1, e.we, e.tag, e.err, e.rdata})
        $display("FAIL rmid_rsp%0d: got v=%b we=%b tag=%0d err=%b rd=%h, want 1 %b %0d %b %h",
                 i, rsp_valid, rsp_we, rsp_tag, rsp_err, rsp_rdata, e.we, e.tag, e.err, e.rdata);
      else n_pass++;
      ack();
    end
    @(negedge clk);
    n_checks++;
    if ({q_count, rsp_valid, CPU_VALID} !== '0)
      $display("FAIL rmid_drained: got q_count=%0d rspv=%b cpuv=%b, want 0", q_count, rsp_valid, CPU_VALID);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
